// File: rtl/fball_rom_arbiter.sv
// rtl/fball_rom_arbiter.sv - round-robin arbiter sharing one fireball sprite ROM
//
// Purpose:
//   N_REQ fireball object engines share one asynchronous-read sprite ROM.
//   A round-robin arbiter accepts one read per cycle into a two-stage
//   registered pipeline:
//     S1 holds the registered ROM address.
//     S2 holds the result registers, presented with valid/ready handshaking.
//   Out-of-range addresses (>= DEPTH) return the transparent colour key.
//   Results leave in the same order they were accepted. At most two reads
//   are in flight at any time.
//
// Ports:
//   Clk        in   system clock, rising edge
//   Reset      in   synchronous active-high reset
//   req        in   per-requester request; the requester holds it, with a
//                   stable address, until it sees gnt
//   req_addr   in   packed addresses; requester i uses [i*ADDR_W +: ADDR_W]
//   gnt        out  one-hot grant, combinational; marks the request that is
//                   accepted at the coming edge
//   rom_addr   out  registered ROM address (the S1 address)
//   rom_color  in   ROM data, combinational from rom_addr
//   rd_valid   out  a result is present
//   rd_ready   in   consumer accepts the result when rd_valid & rd_ready
//   rd_id      out  index of the requester that owns the result
//   rd_color   out  result colour; TRANSP for out-of-range addresses
//   rd_transp  out  result is transparent (colour key hit or out of range)
//   rd_oor     out  address was out of range
module fball_rom_arbiter #(
  parameter int                 N_REQ   = 4,
  parameter int                 ADDR_W  = 9,
  parameter int                 DEPTH   = 441,
  parameter int                 COLOR_W = 12,
  parameter logic [COLOR_W-1:0] TRANSP  = COLOR_W'(12'h808),
  localparam int                ID_W    = $clog2(N_REQ)
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*ADDR_W-1:0] req_addr,
  output logic [N_REQ-1:0]        gnt,
  output logic [ADDR_W-1:0]       rom_addr,
  input  logic [COLOR_W-1:0]      rom_color,
  output logic                    rd_valid,
  input  logic                    rd_ready,
  output logic [ID_W-1:0]         rd_id,
  output logic [COLOR_W-1:0]      rd_color,
  output logic                    rd_transp,
  output logic                    rd_oor
);

  // S1 state; rom_addr is the S1 address register.
  logic            s1_valid;
  logic [ID_W-1:0] s1_id;
  logic            s1_oor;

  // Requester that gets first look in the next arbitration.
  logic [ID_W-1:0] rr_ptr;

  // Pipeline advance conditions.
  logic s2_adv;
  logic s1_adv;

  // Arbitration results.
  logic              grant_any;
  logic              accept;
  logic [ID_W-1:0]   winner;
  logic [ID_W-1:0]   next_ptr;
  logic [ID_W:0]     cand;
  logic [ADDR_W-1:0] win_addr;
  logic              win_oor;
  logic [ADDR_W-1:0] addr_arr [N_REQ];

  // S2 can take a new result when it is empty or its result is being taken.
  // S1 can take a new request when it is empty or it is moving into S2.
  assign s2_adv = !rd_valid || rd_ready;
  assign s1_adv = !s1_valid || s2_adv;

  // Unpack the requester addresses.
  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      addr_arr[i] = req_addr[i*ADDR_W +: ADDR_W];
    end
  end

  // Round-robin search: examine requesters rr_ptr, rr_ptr+1, ... (modulo
  // N_REQ) and stop at the first one that is requesting. cand is one bit
  // wider than an index, so rr_ptr+k (at most 2*N_REQ-2) never overflows
  // before the wrap subtraction.
  always_comb begin
    grant_any = 1'b0;
    winner    = '0;
    cand      = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = {1'b0, rr_ptr} + (ID_W+1)'(k);
      if (cand >= (ID_W+1)'(N_REQ)) begin
        cand = cand - (ID_W+1)'(N_REQ);
      end
      if (!grant_any && req[cand[ID_W-1:0]]) begin
        grant_any = 1'b1;
        winner    = cand[ID_W-1:0];
      end
    end
  end

  assign accept   = s1_adv && grant_any;
  assign next_ptr = (winner == ID_W'(N_REQ-1)) ? '0 : winner + 1'b1;
  assign win_addr = addr_arr[winner];
  // Widen by one bit so the comparison stays correct when DEPTH == 2**ADDR_W.
  assign win_oor  = {1'b0, win_addr} >= (ADDR_W+1)'(DEPTH);

  // Grant is masked during reset, so the accepting edge is never a reset edge.
  always_comb begin
    gnt = '0;
    if (!Reset && accept) begin
      gnt[winner] = 1'b1;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      s1_valid  <= 1'b0;
      s1_id     <= '0;
      s1_oor    <= 1'b0;
      rom_addr  <= '0;
      rr_ptr    <= '0;
      rd_valid  <= 1'b0;
      rd_id     <= '0;
      rd_color  <= '0;
      rd_transp <= 1'b0;
      rd_oor    <= 1'b0;
    end else begin
      // S1: capture the winner. With no request, S1 empties but keeps its
      // address, so the ROM input does not toggle needlessly.
      if (s1_adv) begin
        if (grant_any) begin
          rom_addr <= win_addr;
          s1_id    <= winner;
          s1_oor   <= win_oor;
          s1_valid <= 1'b1;
          rr_ptr   <= next_ptr;
        end else begin
          s1_valid <= 1'b0;
        end
      end

      // S2: sample the ROM output for the address held in S1. The data
      // fields load only with a real result, so an emptied S2 keeps its last
      // values.
      if (s2_adv) begin
        rd_valid <= s1_valid;
        if (s1_valid) begin
          rd_id     <= s1_id;
          rd_oor    <= s1_oor;
          rd_color  <= s1_oor ? TRANSP : rom_color;
          rd_transp <= s1_oor || (rom_color == TRANSP);
        end
      end
    end
  end

endmodule

// File: tb/tb_fball_rom_arbiter.sv
// tb/tb_fball_rom_arbiter.sv - self-checking bench for fball_rom_arbiter
module tb_fball_rom_arbiter;
  localparam int N     = 4;
  localparam int AW    = 9;
  localparam int CW    = 12;
  localparam int DEPTH = 441;

  logic          Clk = 1'b0;
  logic          Reset;
  logic [N-1:0]  req;
  logic [N*AW-1:0] req_addr;
  logic [N-1:0]  gnt;
  logic [AW-1:0] rom_addr;
  logic [CW-1:0] rom_color;
  logic          rd_valid;
  logic          rd_ready;
  logic [1:0]    rd_id;
  logic [CW-1:0] rd_color;
  logic          rd_transp;
  logic          rd_oor;

  logic [CW-1:0] rom_mem [512];
  assign rom_color = rom_mem[rom_addr];

  fball_rom_arbiter dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .req       (req),
    .req_addr  (req_addr),
    .gnt       (gnt),
    .rom_addr  (rom_addr),
    .rom_color (rom_color),
    .rd_valid  (rd_valid),
    .rd_ready  (rd_ready),
    .rd_id     (rd_id),
    .rd_color  (rd_color),
    .rd_transp (rd_transp),
    .rd_oor    (rd_oor)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  // Reference model: ordered list of accepted reads, capacity two.
  // head_out marks that the oldest read has reached the output registers.
  typedef struct {
    int id;
    int addr;
  } item_t;

  item_t q[$];
  bit    head_out;
  int    rr;

  logic            cur_rst;
  logic [N-1:0]    cur_req;
  logic [N*AW-1:0] cur_addr;
  logic            cur_rdy;
  bit              exp_any;
  int              exp_w;

  function automatic logic [N*AW-1:0] pk(input int a0, input int a1, input int a2, input int a3);
    return {AW'(a3), AW'(a2), AW'(a1), AW'(a0)};
  endfunction

  function automatic int addr_of(input logic [N*AW-1:0] a, input int i);
    return int'(a[i*AW +: AW]);
  endfunction

  function automatic logic [CW-1:0] exp_color(input int addr);
    return (addr >= DEPTH) ? 12'h808 : rom_mem[addr];
  endfunction

  function automatic logic exp_tr(input int addr);
    return (addr >= DEPTH) || (rom_mem[addr] == 12'h808);
  endfunction

  // Apply inputs, then at the falling edge compare against the model.
  task automatic drive(input logic rst, input logic [N-1:0] r, input logic [N*AW-1:0] a,
                       input logic rdy);
    bit ev;
    Reset    = rst;
    req      = r;
    req_addr = a;
    rd_ready = rdy;
    cur_rst  = rst;
    cur_req  = r;
    cur_addr = a;
    cur_rdy  = rdy;
    @(negedge Clk);
    exp_any = 1'b0;
    exp_w   = 0;
    if (!rst && r != '0 && (q.size() < 2 || rdy)) begin
      for (int k = 0; k < N; k++) begin
        if (!exp_any && r[(rr + k) % N]) begin
          exp_any = 1'b1;
          exp_w   = (rr + k) % N;
        end
      end
    end
    chk("m_gnt", 32'(gnt), exp_any ? (32'd1 << exp_w) : 32'd0);
    ev = (q.size() > 0) && head_out;
    chk("m_rd_valid", 32'(rd_valid), 32'(ev));
    if (ev) begin
      chk("m_rd_id", 32'(rd_id), 32'(q[0].id));
      chk("m_rd_color", 32'(rd_color), 32'(exp_color(q[0].addr)));
      chk("m_rd_transp", 32'(rd_transp), 32'(exp_tr(q[0].addr)));
      chk("m_rd_oor", 32'(rd_oor), 32'(q[0].addr >= DEPTH));
    end
  endtask

  // Clock edge, then update the model.
  task automatic tick();
    bit adv;
    @(posedge Clk);
    #1;
    if (cur_rst) begin
      q.delete();
      head_out = 1'b0;
      rr       = 0;
    end else begin
      adv = 1'b1;
      if (q.size() > 0 && head_out) begin
        if (cur_rdy) begin
          void'(q.pop_front());
          head_out = 1'b0;
        end else begin
          adv = 1'b0;
        end
      end
      if (adv && q.size() > 0) head_out = 1'b1;
      if (exp_any) begin
        q.push_back('{exp_w, addr_of(cur_addr, exp_w)});
        rr = (exp_w + 1) % N;
      end
    end
  endtask

  typedef struct {
    logic            rst;
    logic [N-1:0]    req;
    logic [N*AW-1:0] addr;
    logic            rdy;
    logic [N-1:0]    g;
    logic            v;
    logic [1:0]      id;
    logic [CW-1:0]   col;
    logic            tr;
    logic            oor;
  } vec_t;

  function automatic vec_t mk(input logic rst, input logic [3:0] r, input logic [N*AW-1:0] a,
                              input logic [3:0] g, input logic v, input logic [1:0] id,
                              input logic [11:0] col, input logic tr, input logic oor);
    vec_t t;
    t.rst  = rst;
    t.req  = r;
    t.addr = a;
    t.rdy  = 1'b1;
    t.g    = g;
    t.v    = v;
    t.id   = id;
    t.col  = col;
    t.tr   = tr;
    t.oor  = oor;
    return t;
  endfunction

  vec_t tbl[$];

  initial begin
    logic [N*AW-1:0] a1, a2, a4, a5, ab;
    logic [CW-1:0]   v;

    for (int i = 0; i < 512; i++) begin
      v = CW'($urandom);
      if (v == 12'h808) v = 12'h809;
      rom_mem[i] = v;
    end
    rom_mem[0]   = 12'h808;
    rom_mem[5]   = 12'hF30;
    rom_mem[10]  = 12'h111;
    rom_mem[11]  = 12'h222;
    rom_mem[12]  = 12'h333;
    rom_mem[13]  = 12'h444;
    rom_mem[440] = 12'hABC;
    rom_mem[441] = 12'h123;
    rom_mem[511] = 12'h456;

    a1 = pk(5, 0, 0, 0);
    a2 = pk(10, 11, 12, 13);
    a4 = pk(0, 440, 441, 511);
    a5 = pk(0, 0, 0, 0);

    // Single read, round-robin with all requesters, range boundary, colour key.
    tbl.push_back(mk(1, 4'b0000, a1, 4'b0000, 0, 0, 12'h000, 0, 0));
    tbl.push_back(mk(0, 4'b0001, a1, 4'b0001, 0, 0, 12'h000, 0, 0));
    tbl.push_back(mk(0, 4'b0000, a1, 4'b0000, 0, 0, 12'h000, 0, 0));
    tbl.push_back(mk(0, 4'b0000, a1, 4'b0000, 1, 0, 12'hF30, 0, 0));
    tbl.push_back(mk(0, 4'b1111, a2, 4'b0010, 0, 0, 12'h000, 0, 0));
    tbl.push_back(mk(0, 4'b1111, a2, 4'b0100, 0, 0, 12'h000, 0, 0));
    tbl.push_back(mk(0, 4'b1111, a2, 4'b1000, 1, 1, 12'h222, 0, 0));
    tbl.push_back(mk(0, 4'b1111, a2, 4'b0001, 1, 2, 12'h333, 0, 0));
    tbl.push_back(mk(0, 4'b1111, a2, 4'b0010, 1, 3, 12'h444, 0, 0));
    tbl.push_back(mk(0, 4'b1111, a2, 4'b0100, 1, 0, 12'h111, 0, 0));
    tbl.push_back(mk(0, 4'b1111, a2, 4'b1000, 1, 1, 12'h222, 0, 0));
    tbl.push_back(mk(0, 4'b1111, a2, 4'b0001, 1, 2, 12'h333, 0, 0));
    tbl.push_back(mk(0, 4'b0000, a2, 4'b0000, 1, 3, 12'h444, 0, 0));
    tbl.push_back(mk(0, 4'b0000, a2, 4'b0000, 1, 0, 12'h111, 0, 0));
    tbl.push_back(mk(0, 4'b0000, a2, 4'b0000, 0, 0, 12'h000, 0, 0));
    tbl.push_back(mk(0, 4'b1110, a4, 4'b0010, 0, 0, 12'h000, 0, 0));
    tbl.push_back(mk(0, 4'b1110, a4, 4'b0100, 0, 0, 12'h000, 0, 0));
    tbl.push_back(mk(0, 4'b1110, a4, 4'b1000, 1, 1, 12'hABC, 0, 0));
    tbl.push_back(mk(0, 4'b0000, a4, 4'b0000, 1, 2, 12'h808, 1, 1));
    tbl.push_back(mk(0, 4'b0000, a4, 4'b0000, 1, 3, 12'h808, 1, 1));
    tbl.push_back(mk(0, 4'b0001, a5, 4'b0001, 0, 0, 12'h000, 0, 0));
    tbl.push_back(mk(0, 4'b0000, a5, 4'b0000, 0, 0, 12'h000, 0, 0));
    tbl.push_back(mk(0, 4'b0000, a5, 4'b0000, 1, 0, 12'h808, 1, 0));
    tbl.push_back(mk(0, 4'b0000, a5, 4'b0000, 0, 0, 12'h000, 0, 0));

    // Initial reset, then check the reset state.
    Reset    = 1'b1;
    req      = '0;
    req_addr = '0;
    rd_ready = 1'b1;
    q.delete();
    head_out = 1'b0;
    rr       = 0;
    repeat (2) @(posedge Clk);
    #1;
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("rst_rom_addr", 32'(rom_addr), 32'd0);
    chk("rst_rd_id", 32'(rd_id), 32'd0);
    chk("rst_rd_color", 32'(rd_color), 32'd0);
    chk("rst_rd_transp", 32'(rd_transp), 32'd0);
    chk("rst_rd_oor", 32'(rd_oor), 32'd0);

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].rst, tbl[i].req, tbl[i].addr, tbl[i].rdy);
      chk($sformatf("t%0d_gnt", i), 32'(gnt), 32'(tbl[i].g));
      chk($sformatf("t%0d_valid", i), 32'(rd_valid), 32'(tbl[i].v));
      if (tbl[i].v) begin
        chk($sformatf("t%0d_id", i), 32'(rd_id), 32'(tbl[i].id));
        chk($sformatf("t%0d_color", i), 32'(rd_color), 32'(tbl[i].col));
        chk($sformatf("t%0d_transp", i), 32'(rd_transp), 32'(tbl[i].tr));
        chk($sformatf("t%0d_oor", i), 32'(rd_oor), 32'(tbl[i].oor));
      end
      tick();
    end

    // Backpressure: two reads accepted, consumer stalls for three cycles.
    ab = pk(0, 10, 11, 12);
    drive(0, 4'b0010, ab, 0);
    chk("bp_gnt_a", 32'(gnt), 32'h2);
    tick();
    drive(0, 4'b0100, ab, 0);
    chk("bp_gnt_b", 32'(gnt), 32'h4);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(0, 4'b1000, ab, 0);
      chk("bp_stall_gnt", 32'(gnt), 32'd0);
      chk("bp_stall_valid", 32'(rd_valid), 32'd1);
      chk("bp_stall_id", 32'(rd_id), 32'd1);
      chk("bp_stall_color", 32'(rd_color), 32'h111);
      chk("bp_stall_rom_addr", 32'(rom_addr), 32'd11);
      tick();
    end
    drive(0, 4'b0000, ab, 1);
    chk("bp_out1_id", 32'(rd_id), 32'd1);
    chk("bp_out1_color", 32'(rd_color), 32'h111);
    tick();
    drive(0, 4'b0000, ab, 1);
    chk("bp_out2_valid", 32'(rd_valid), 32'd1);
    chk("bp_out2_id", 32'(rd_id), 32'd2);
    chk("bp_out2_color", 32'(rd_color), 32'h222);
    tick();
    drive(0, 4'b0000, ab, 1);
    chk("bp_drained", 32'(rd_valid), 32'd0);
    tick();

    // Reset with two reads in flight.
    drive(0, 4'b0001, pk(5, 0, 0, 0), 0);
    chk("rf_gnt_a", 32'(gnt), 32'h1);
    tick();
    drive(0, 4'b0010, pk(0, 13, 0, 0), 0);
    chk("rf_gnt_b", 32'(gnt), 32'h2);
    tick();
    drive(1, 4'b1010, pk(0, 12, 0, 13), 1);
    chk("rf_rst_gnt", 32'(gnt), 32'd0);
    tick();
    drive(0, 4'b1010, pk(0, 12, 0, 13), 1);
    chk("rf_after_valid", 32'(rd_valid), 32'd0);
    chk("rf_after_gnt", 32'(gnt), 32'h2);
    tick();
    repeat (3) begin
      drive(0, 4'b0000, pk(0, 0, 0, 0), 1);
      tick();
    end

    // Randomised traffic against the model.
    for (int i = 0; i < 600; i++) begin
      drive(($urandom_range(0, 99) == 0),
            4'($urandom_range(0, 15)),
            pk($urandom_range(0, 511), $urandom_range(0, 511),
               $urandom_range(0, 511), $urandom_range(0, 511)),
            ($urandom_range(0, 3) != 0));
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
